controller_pulse_reset_pio: RTL and testbench

- Parametrised Avalon-MM output PIO that drives per-peripheral reset/enable lines; it succeeds the fixed 3-bit set/clear reset-control ports.
- Adds configurable width, a programmable reset value and a toggle register.
- Adds a hardware timed-pulse engine: bits written to the PULSE register assert, then self-deassert after PULSE_LEN clocks.
- Sits on the system interconnect as a zero-wait-state slave; out_port fans out to UART/peripheral reset inputs.

---
 rtl/controller_pulse_reset_pio.sv | 156 +++++++++++++++
 tb/tb_controller_pulse_reset_pio.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_pulse_reset_pio.sv
// Avalon-MM output PIO driving reset/enable lines, with set/clear/toggle and a timed-pulse engine.
// Optional pulse-done interrupt: define CONTROLLER_PIO_PULSE_IRQ_EN to add the irq port.
module controller_pulse_reset_pio #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      CNT_W       = 16,
  parameter int unsigned      LEN_DEFAULT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_LEN    = 3'd1;
  localparam logic [2:0] ADDR_PULSE  = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLR    = 3'd5;
  localparam logic [2:0] ADDR_TOGGLE = 3'd6;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data_out, w_data_nxt;
  logic [WIDTH-1:0] r_pulse_mask, w_mask_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [CNT_W-1:0] r_pulse_len, w_len_nxt;
  logic             w_irq_pend;
  logic             w_wr;
  logic             w_expire;
  logic [WIDTH-1:0] w_wd;
  logic [CNT_W-1:0] w_load;
  logic             w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_load   = (r_pulse_len == '0) ? CNT_W'(1) : r_pulse_len;
  assign w_expire = (r_state == ACTIVE) && (r_count == CNT_W'(1));
  assign w_unused = ^writedata;
  assign out_port = r_data_out;

`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
  logic r_irq_pend, w_irq_nxt;
  assign w_irq_pend = r_irq_pend;
  assign irq        = r_irq_pend;
`else
  assign w_irq_pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out   <= RESET_VALUE;
      r_pulse_mask <= '0;
      r_count      <= '0;
      r_pulse_len  <= CNT_W'(LEN_DEFAULT);
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
      r_irq_pend   <= 1'b0;
`endif
    end else begin
      r_data_out   <= w_data_nxt;
      r_pulse_mask <= w_mask_nxt;
      r_count      <= w_count_nxt;
      r_pulse_len  <= w_len_nxt;
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
      r_irq_pend   <= w_irq_nxt;
`endif
    end
  end

  // Expiry is resolved first; a coincident CPU write then acts on the post-expiry values.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data_out;
    w_mask_nxt  = r_pulse_mask;
    w_count_nxt = r_count;
    w_len_nxt   = r_pulse_len;
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
    w_irq_nxt   = r_irq_pend;
`endif

    if (w_expire) begin
      w_data_nxt  = r_data_out & ~r_pulse_mask;
      w_mask_nxt  = '0;
      w_count_nxt = '0;
      w_state_nxt = IDLE;
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
      w_irq_nxt   = 1'b1;
`endif
    end else if (r_state == ACTIVE) begin
      w_count_nxt = r_count - CNT_W'(1);
    end

    if (w_wr) begin
      case (address)
        ADDR_DATA: begin
          w_data_nxt  = w_wd;
          w_mask_nxt  = '0;
          w_count_nxt = '0;
          w_state_nxt = IDLE;
        end
        ADDR_LEN: w_len_nxt = writedata[CNT_W-1:0];
        ADDR_PULSE: begin
          if (w_wd != '0) begin
            w_data_nxt  = w_data_nxt | w_wd;
            w_mask_nxt  = w_mask_nxt | w_wd;
            w_count_nxt = w_load;
            w_state_nxt = ACTIVE;
          end
        end
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
        ADDR_STATUS: begin
          if (writedata[1] && !w_expire) w_irq_nxt = 1'b0;
        end
`endif
        ADDR_SET, ADDR_CLR, ADDR_TOGGLE: begin
          if (address == ADDR_SET)      w_data_nxt = w_data_nxt | w_wd;
          else if (address == ADDR_CLR) w_data_nxt = w_data_nxt & ~w_wd;
          else                          w_data_nxt = w_data_nxt ^ w_wd;
          w_mask_nxt = w_mask_nxt & ~w_wd;
          if (w_mask_nxt == '0) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = r_data_out;
      ADDR_LEN:    readdata[CNT_W-1:0] = r_pulse_len;
      ADDR_PULSE:  readdata[WIDTH-1:0] = r_pulse_mask;
      ADDR_STATUS: readdata[1:0]       = {w_irq_pend, r_state == ACTIVE};
      default:     readdata            = '0;
    endcase
  end

endmodule

// File: tb/tb_controller_pulse_reset_pio.sv
// Scoreboard bench for controller_pulse_reset_pio: expected out_port values are queued as stimulus is driven.
module tb_controller_pulse_reset_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  controller_pulse_reset_pio #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .CNT_W(16), .LEN_DEFAULT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // Drives one write so that it is sampled by the next rising edge; returns on the following falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (out_port !== 8'hA5) begin errors++; $display("FAIL reset_out: got %h expected a5", out_port); end
    address = 3'd1; #1;
    checks++;
    if (readdata !== 32'd16) begin errors++; $display("FAIL reset_len: got %0d expected 16", readdata); end
    address = 3'd3; #1;
    checks++;
    if (readdata !== 32'd0) begin errors++; $display("FAIL reset_status: got %h expected 0", readdata); end
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_port !== 8'hA5) begin errors++; $display("FAIL release_out: got %h expected a5", out_port); end
  endtask

  task automatic test_data_set_clr_toggle;
    logic [2:0] addrs [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
    logic [7:0] wds   [4] = '{8'h0F, 8'h30, 8'h01, 8'hFF};
    exp_q.push_back(8'h0F); exp_q.push_back(8'h3F);
    exp_q.push_back(8'h3E); exp_q.push_back(8'hC1);
    for (int i = 0; i < 4; i++) begin
      bus_write(addrs[i], {24'd0, wds[i]});
      address = 3'd0; #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (out_port !== exp_v) begin errors++; $display("FAIL rw_out[%0d]: got %h expected %h", i, out_port, exp_v); end
      checks++;
      if (readdata !== {24'd0, exp_v}) begin errors++; $display("FAIL rw_read[%0d]: got %h expected %h", i, readdata, exp_v); end
    end
  endtask

  task automatic test_pulse;
    bus_write(3'd1, 32'd5);
    bus_write(3'd0, 32'd0);
    bus_write(3'd2, 32'h04);
    repeat (5) exp_q.push_back(8'h04);
    exp_q.push_back(8'h00);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      address = 3'd3; #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (out_port !== exp_v) begin errors++; $display("FAIL pulse_out[%0d]: got %h expected %h", i, out_port, exp_v); end
      checks++;
      if (readdata[0] !== (exp_v != 8'h00)) begin errors++; $display("FAIL pulse_active[%0d]: got %b expected %b", i, readdata[0], exp_v != 8'h00); end
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
      checks++;
      if (irq !== (exp_v == 8'h00)) begin errors++; $display("FAIL pulse_irq[%0d]: got %b expected %b", i, irq, exp_v == 8'h00); end
`endif
    end
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
    checks++;
    if (readdata !== 32'h2) begin errors++; $display("FAIL pulse_status_pend: got %h expected 2", readdata); end
    bus_write(3'd3, 32'h2);
    address = 3'd3; #1;
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got status %h irq %b expected 0 0", readdata, irq); end
`else
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL pulse_status_idle: got %h expected 0", readdata); end
`endif
  endtask

  task automatic test_retrigger;
    bus_write(3'd1, 32'd10);
    bus_write(3'd0, 32'd0);
    bus_write(3'd2, 32'h01);
    repeat (4) exp_q.push_back(8'h01);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (out_port !== exp_v) begin errors++; $display("FAIL retrig_a[%0d]: got %h expected %h", i, out_port, exp_v); end
    end
    bus_write(3'd2, 32'h02);
    repeat (10) exp_q.push_back(8'h03);
    exp_q.push_back(8'h00);
    for (int i = 0; i < 11; i++) begin
      if (i != 0) @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (out_port !== exp_v) begin errors++; $display("FAIL retrig_b[%0d]: got %h expected %h", i, out_port, exp_v); end
    end
    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'h01);
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    for (int i = 0; i < 2; i++) begin
      if (i != 0) @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (out_port !== exp_v) begin errors++; $display("FAIL len0[%0d]: got %h expected %h", i, out_port, exp_v); end
    end
  endtask

  task automatic test_cancel_collision;
    bus_write(3'd1, 32'd6);
    bus_write(3'd0, 32'd0);
    bus_write(3'd2, 32'h0C);
    repeat (2) exp_q.push_back(8'h0C);
    for (int i = 0; i < 2; i++) begin
      if (i != 0) @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (out_port !== exp_v) begin errors++; $display("FAIL cancel_a[%0d]: got %h expected %h", i, out_port, exp_v); end
    end
    bus_write(3'd5, 32'h04);
    address = 3'd2; #1;
    checks++;
    if (readdata !== 32'h08) begin errors++; $display("FAIL cancel_mask: got %h expected 08", readdata); end
    repeat (4) exp_q.push_back(8'h08);
    exp_q.push_back(8'h00);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (out_port !== exp_v) begin errors++; $display("FAIL cancel_b[%0d]: got %h expected %h", i, out_port, exp_v); end
    end
    bus_write(3'd1, 32'd3);
    bus_write(3'd2, 32'h01);
    repeat (3) exp_q.push_back(8'h01);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (out_port !== exp_v) begin errors++; $display("FAIL collide_a[%0d]: got %h expected %h", i, out_port, exp_v); end
    end
    bus_write(3'd4, 32'h01);
    repeat (2) exp_q.push_back(8'h01);
    for (int i = 0; i < 2; i++) begin
      if (i != 0) @(negedge clk);
      address = 3'd3; #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (out_port !== exp_v) begin errors++; $display("FAIL collide_b[%0d]: got %h expected %h", i, out_port, exp_v); end
      checks++;
      if (readdata[0] !== 1'b0) begin errors++; $display("FAIL collide_active[%0d]: got %b expected 0", i, readdata[0]); end
    end
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL collide_irq: got %b expected 1", irq); end
`endif
  endtask

  task automatic test_reset_mid_pulse;
    bus_write(3'd1, 32'd10);
    bus_write(3'd0, 32'd0);
    bus_write(3'd2, 32'h40);
    repeat (2) @(negedge clk);
    address = 3'd3; #1;
    checks++;
    if (out_port !== 8'h40 || readdata[0] !== 1'b1) begin errors++; $display("FAIL midpulse_pre: got out %h active %b expected 40 1", out_port, readdata[0]); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== 8'hA5) begin errors++; $display("FAIL midpulse_async: got %h expected a5", out_port); end
`ifdef CONTROLLER_PIO_PULSE_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL midpulse_irq: got %b expected 0", irq); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    address = 3'd3; #1;
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL midpulse_status: got %h expected 0", readdata); end
    address = 3'd2; #1;
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL midpulse_mask: got %h expected 0", readdata); end
    address = 3'd1; #1;
    checks++;
    if (readdata !== 32'd16) begin errors++; $display("FAIL midpulse_len: got %0d expected 16", readdata); end
    checks++;
    if (out_port !== 8'hA5) begin errors++; $display("FAIL midpulse_out: got %h expected a5", out_port); end
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;
    test_reset();
    test_data_set_clr_toggle();
    test_pulse();
    test_retrigger();
    test_cancel_collision();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
